// File: rtl/mem_swap_ctrl_pkg.sv
// Shared definitions for the memory swap controller: FSM state encodings and counter width.
package mem_swap_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        WR_A = 3'd3,
        WR_B = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam int CNT_W = 8;

endpackage

// File: rtl/mem_swap_ctrl.sv
// Swaps the contents of two register-file words: read A, read B, write B-data to A,
// write A-data to B. Drives the memory's async read port and sync write port directly.
module mem_swap_ctrl
    import mem_swap_ctrl_pkg::*;
#(
    parameter int width   = 7,
    parameter int depth   = 8,
    parameter int n_words = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [width-1:0] addr_a,
    input  logic [width-1:0] addr_b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] swap_cnt,
    output logic [width-1:0] mem_address_r,
    input  logic [depth-1:0] mem_data_r,
    output logic             mem_we,
    output logic [width-1:0] mem_address_w,
    output logic [depth-1:0] mem_data_w
);

    localparam logic [width-1:0] LIMIT = width'(n_words);

    state_t           state_q, state_d;
    logic [width-1:0] a_q, b_q;
    logic [depth-1:0] tmp_a, tmp_b;
    logic             err_q, err_d;
    logic             load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            tmp_a    <= '0;
            tmp_b    <= '0;
            err_q    <= 1'b0;
            swap_cnt <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (load) begin
                a_q <= addr_a;
                b_q <= addr_b;
            end
            if (state_q == RD_A) tmp_a <= mem_data_r;
            if (state_q == RD_B) tmp_b <= mem_data_r;
            if (state_q == DONE) swap_cnt <= swap_cnt + 1'b1;
        end
    end

    // Memory-side outputs and done depend only on state and latched operands, never on start/addr.
    always_comb begin
        state_d       = state_q;
        load          = 1'b0;
        err_d         = 1'b0;
        done          = 1'b0;
        mem_address_r = '0;
        mem_we        = 1'b0;
        mem_address_w = '0;
        mem_data_w    = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (addr_a < LIMIT && addr_b < LIMIT) begin
                        load    = 1'b1;
                        state_d = RD_A;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RD_A: begin
                mem_address_r = a_q;
                state_d       = RD_B;
            end
            RD_B: begin
                mem_address_r = b_q;
                state_d       = WR_A;
            end
            WR_A: begin
                mem_we        = 1'b1;
                mem_address_w = a_q;
                mem_data_w    = tmp_b;
                state_d       = WR_B;
            end
            WR_B: begin
                mem_we        = 1'b1;
                mem_address_w = b_q;
                mem_data_w    = tmp_a;
                state_d       = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign err  = err_q;

endmodule

// File: tb/tb_mem_swap_ctrl.sv
// Directed bench for mem_swap_ctrl with a register-file model (sync write, async read) as memory.
module tb_mem_swap_ctrl;

    localparam int W = 7;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] addr_a = '0;
    logic [W-1:0] addr_b = '0;
    logic         busy, done, err, mem_we;
    logic [7:0]   swap_cnt;
    logic [W-1:0] mem_address_r, mem_address_w;
    logic [D-1:0] mem_data_r, mem_data_w;

    logic [D-1:0] mem [0:(1<<W)-1];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Register-file model; the bench preloads it directly between edges.
    always @(posedge clk) begin
        if (mem_we) mem[mem_address_w] <= mem_data_w;
    end
    assign mem_data_r = mem[mem_address_r];

    mem_swap_ctrl #(.width(W), .depth(D), .n_words(7)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .addr_a(addr_a), .addr_b(addr_b),
        .busy(busy), .done(done), .err(err), .swap_cnt(swap_cnt),
        .mem_address_r(mem_address_r), .mem_data_r(mem_data_r), .mem_we(mem_we),
        .mem_address_w(mem_address_w), .mem_data_w(mem_data_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic run_swap(input logic [W-1:0] a, input logic [W-1:0] b);
        start  = 1'b1;
        addr_a = a;
        addr_b = b;
        tick();
        start = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if ({busy, done, err, mem_we} !== 4'b0000) begin n_bad++; $display("[TB] FAIL reset_flags: got %b want 0000", {busy, done, err, mem_we}); end
        n_cmp++; if (swap_cnt !== 8'd0) begin n_bad++; $display("[TB] FAIL reset_cnt: got %0d want 0", swap_cnt); end
        mem[2] = 8'hA5; mem[5] = 8'h3C;
        start = 1'b1; addr_a = 7'd2; addr_b = 7'd5;
        tick();
        start = 1'b0;
        tick();
        n_cmp++; if (mem_address_r !== 7'd5) begin n_bad++; $display("[TB] FAIL pre_reset_rd_b: got %0d want 5", mem_address_r); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({busy, done, err, mem_we} !== 4'b0000) begin n_bad++; $display("[TB] FAIL midrun_flags: got %b want 0000", {busy, done, err, mem_we}); end
        n_cmp++; if ({mem_address_r, mem_address_w, mem_data_w, swap_cnt} !== '0) begin n_bad++; $display("[TB] FAIL midrun_buses: rd=%0d wa=%0d wd=%h cnt=%0d want all 0", mem_address_r, mem_address_w, mem_data_w, swap_cnt); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_swap();
        do_reset();
        mem[2] = 8'hA5; mem[5] = 8'h3C;
        start = 1'b1; addr_a = 7'd2; addr_b = 7'd5;
        tick();
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1 || mem_address_r !== 7'd2 || mem_we !== 1'b0) begin n_bad++; $display("[TB] FAIL swap_rd_a: busy=%b rd=%0d we=%b want 1/2/0", busy, mem_address_r, mem_we); end
        tick();
        n_cmp++; if (mem_address_r !== 7'd5) begin n_bad++; $display("[TB] FAIL swap_rd_b: got %0d want 5", mem_address_r); end
        tick();
        n_cmp++; if (mem_we !== 1'b1 || mem_address_w !== 7'd2 || mem_data_w !== 8'h3C) begin n_bad++; $display("[TB] FAIL swap_wr_a: we=%b wa=%0d wd=%h want 1/2/3c", mem_we, mem_address_w, mem_data_w); end
        tick();
        n_cmp++; if (mem[2] !== 8'h3C || mem_address_w !== 7'd5 || mem_data_w !== 8'hA5) begin n_bad++; $display("[TB] FAIL swap_wr_b: m2=%h wa=%0d wd=%h want 3c/5/a5", mem[2], mem_address_w, mem_data_w); end
        tick();
        n_cmp++; if (done !== 1'b1 || mem_we !== 1'b0 || mem[5] !== 8'hA5 || swap_cnt !== 8'd0) begin n_bad++; $display("[TB] FAIL swap_done: done=%b we=%b m5=%h cnt=%0d want 1/0/a5/0", done, mem_we, mem[5], swap_cnt); end
        tick();
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || swap_cnt !== 8'd1) begin n_bad++; $display("[TB] FAIL swap_exit: done=%b busy=%b cnt=%0d want 0/0/1", done, busy, swap_cnt); end
    endtask

    task automatic test_same_addr();
        int we_hits;
        do_reset();
        mem[4] = 8'h11;
        we_hits = 0;
        start = 1'b1; addr_a = 7'd4; addr_b = 7'd4;
        tick();
        start = 1'b0;
        repeat (5) begin
            if (mem_we === 1'b1 && mem_address_w === 7'd4) we_hits++;
            tick();
        end
        n_cmp++; if (we_hits !== 2) begin n_bad++; $display("[TB] FAIL same_we_pulses: got %0d want 2", we_hits); end
        n_cmp++; if (mem[4] !== 8'h11 || swap_cnt !== 8'd1) begin n_bad++; $display("[TB] FAIL same_result: m4=%h cnt=%0d want 11/1", mem[4], swap_cnt); end
    endtask

    task automatic test_illegal();
        do_reset();
        start = 1'b1; addr_a = 7'd7; addr_b = 7'd1;
        tick();
        start = 1'b0;
        n_cmp++; if (err !== 1'b1 || busy !== 1'b0 || mem_we !== 1'b0) begin n_bad++; $display("[TB] FAIL illegal_a: err=%b busy=%b we=%b want 1/0/0", err, busy, mem_we); end
        tick();
        n_cmp++; if (err !== 1'b0 || swap_cnt !== 8'd0) begin n_bad++; $display("[TB] FAIL illegal_a_after: err=%b cnt=%0d want 0/0", err, swap_cnt); end
        start = 1'b1; addr_a = 7'd1; addr_b = 7'd100;
        tick();
        start = 1'b0;
        n_cmp++; if (err !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("[TB] FAIL illegal_b: err=%b busy=%b want 1/0", err, busy); end
        start = 1'b1; addr_a = 7'd6; addr_b = 7'd6;
        tick();
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1 || err !== 1'b0) begin n_bad++; $display("[TB] FAIL legal_edge: busy=%b err=%b want 1/0", busy, err); end
        repeat (5) tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'hA5; mem[5] = 8'h3C;
        start = 1'b1; addr_a = 7'd2; addr_b = 7'd5;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; addr_a = 7'd0; addr_b = 7'd1;
        tick();
        start = 1'b0;
        tick();
        tick();
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_done: got %b want 1", done); end
        start = 1'b1; addr_a = 7'd0; addr_b = 7'd1;
        tick();
        n_cmp++; if (busy !== 1'b0 || swap_cnt !== 8'd1 || mem[0] !== 8'h01 || mem[1] !== 8'h02 || mem[2] !== 8'h3C) begin n_bad++; $display("[TB] FAIL b2b_ignored: busy=%b cnt=%0d m0=%h m1=%h m2=%h want 0/1/01/02/3c", busy, swap_cnt, mem[0], mem[1], mem[2]); end
        addr_a = 7'd2; addr_b = 7'd5;
        tick();
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1 || mem_address_r !== 7'd2) begin n_bad++; $display("[TB] FAIL b2b_accept: busy=%b rd=%0d want 1/2", busy, mem_address_r); end
        repeat (5) tick();
        n_cmp++; if (swap_cnt !== 8'd2 || mem[2] !== 8'hA5 || mem[5] !== 8'h3C) begin n_bad++; $display("[TB] FAIL b2b_second: cnt=%0d m2=%h m5=%h want 2/a5/3c", swap_cnt, mem[2], mem[5]); end
    endtask

    task automatic test_reset_wr_b();
        do_reset();
        mem[2] = 8'hA5; mem[5] = 8'h3C;
        start = 1'b1; addr_a = 7'd2; addr_b = 7'd5;
        tick();
        start = 1'b0;
        repeat (3) tick();
        n_cmp++; if (mem_we !== 1'b1 || mem_address_w !== 7'd5) begin n_bad++; $display("[TB] FAIL wrb_reached: we=%b wa=%0d want 1/5", mem_we, mem_address_w); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_we !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("[TB] FAIL wrb_reset_drop: we=%b busy=%b want 0/0", mem_we, busy); end
        tick();
        n_cmp++; if (mem[2] !== 8'h3C || mem[5] !== 8'h3C) begin n_bad++; $display("[TB] FAIL wrb_no_rollback: m2=%h m5=%h want 3c/3c", mem[2], mem[5]); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b0 || swap_cnt !== 8'd0) begin n_bad++; $display("[TB] FAIL wrb_idle: busy=%b cnt=%0d want 0/0", busy, swap_cnt); end
    endtask

    task automatic test_cnt_wrap();
        do_reset();
        for (int i = 0; i < 255; i++) run_swap(7'd0, 7'd1);
        n_cmp++; if (swap_cnt !== 8'd255) begin n_bad++; $display("[TB] FAIL wrap_255: got %0d want 255", swap_cnt); end
        run_swap(7'd0, 7'd1);
        n_cmp++; if (swap_cnt !== 8'd0) begin n_bad++; $display("[TB] FAIL wrap_0: got %0d want 0", swap_cnt); end
    endtask

    initial begin
        for (int i = 0; i < (1 << W); i++) mem[i] = '0;
        test_reset();
        test_swap();
        test_same_addr();
        test_illegal();
        test_back_to_back();
        test_reset_wr_b();
        test_cnt_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
